// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;

    localparam logic [3:0] MASK_NONE = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory bus between fetch and data ports, one access in flight.
// Latency: grant cycle then ack cycle (2 minimum); done/rdata are combinational from mem_ack.
// Backpressure: requesters are stalled until their done pulse; optional timeout aborts a stuck access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic        i_stall,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,

    output logic        bus_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit            TMO_EN     = (TIMEOUT != 0);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          busy;
    logic          grant_i;
    logic          grant_d;
    logic          tmo_hit;
    logic          finish;

    assign busy    = (state != IDLE);
    // Fetch wins a conflict only once data has won STARVE_LIMIT conflicts in a row.
    assign grant_i = !busy && i_req && (!d_req || (starve_cnt == STARVE_MAX));
    assign grant_d = !busy && d_req && !grant_i;
    assign tmo_hit = TMO_EN && busy && !mem_ack && (tmo_cnt == TMO_LAST);
    assign finish  = busy && (mem_ack || tmo_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt = BUSY_I;
                end else if (grant_d) begin
                    state_nxt = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A requester that dropped its request mid-access gets no done; reset abandons the access.
    always_comb begin
        mem_req = 1'b0;
        i_done  = 1'b0;
        d_done  = 1'b0;
        bus_err = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        case (state)
            BUSY_I: begin
                mem_req = 1'b1;
                if (finish && i_req && !reset) begin
                    i_done  = 1'b1;
                    bus_err = tmo_hit;
                    i_rdata = mem_ack ? mem_rdata : '0;
                end
            end
            BUSY_D: begin
                mem_req = 1'b1;
                if (finish && d_req && !reset) begin
                    d_done  = 1'b1;
                    bus_err = tmo_hit;
                    d_rdata = (mem_ack && !mem_we) ? mem_rdata : '0;
                end
            end
            default: mem_req = 1'b0;
        endcase
    end

    assign i_stall = i_req && !i_done;
    assign d_stall = d_req && !d_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= MASK_NONE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (grant_i) begin
                mem_we     <= 1'b0;
                mem_addr   <= i_addr;
                mem_wdata  <= '0;
                mem_wmask  <= MASK_NONE;
                starve_cnt <= '0;
            end else if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wmask <= d_we ? d_wmask : MASK_NONE;
                if (i_req && (starve_cnt != STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
            if (!busy) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule
